// File: rtl/mem_port_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single memory port.
// A request accepted in IDLE is latched onto the mem_* bus.
// The bus is held through XFER until mem_ack arrives or the wait limit expires.
// A one-cycle DONE state then raises the owner's completion pulse.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 48,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   // CPU master
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_sz,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_enable,
   // DMA master
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [1:0]        dma_sz,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_done,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_sz,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   // shared status
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              owner
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             last_grant_reg;   // 1 = DMA was granted last
   logic             grant_dma;

   // Round-robin pick: a tie goes to the master that was not served last
   always_comb begin
      grant_dma = dma_req;
      if (cpu_req && dma_req) begin
         grant_dma = ~last_grant_reg;
      end
   end

   // The CPU is stalled while it requests and its transfer has not reached DONE
   assign cpu_enable = rst_n & ~(cpu_req & ~((state_reg == S_DONE) & ~owner));

   // Arbitration FSM, memory bus registers, read data and completion status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
         owner          <= 1'b0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_sz         <= 2'd0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         rdata          <= '0;
         err            <= 1'b0;
         dma_done       <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cpu_req || dma_req) begin
                  owner          <= grant_dma;
                  last_grant_reg <= grant_dma;
                  mem_we         <= grant_dma ? dma_we    : cpu_we;
                  mem_sz         <= grant_dma ? dma_sz    : cpu_sz;
                  mem_addr       <= grant_dma ? dma_addr  : cpu_addr;
                  mem_wdata      <= grant_dma ? dma_wdata : cpu_wdata;
                  mem_req        <= 1'b1;
                  cnt_reg        <= '0;
                  state_reg      <= S_XFER;
               end
            end
            S_XFER: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     rdata <= mem_rdata;
                  end
                  mem_req   <= 1'b0;
                  dma_done  <= owner;
                  cnt_reg   <= '0;
                  state_reg <= S_DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  // abort: no ack within the wait window
                  rdata     <= '0;
                  err       <= 1'b1;
                  mem_req   <= 1'b0;
                  dma_done  <= owner;
                  cnt_reg   <= '0;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_DONE: begin
               dma_done  <= 1'b0;
               err       <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Each accepted transfer pushes its expected outcome to a queue.
// The entry is popped and compared on the DONE cycle.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 48;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, dma_req, dma_we, mem_ack;
   logic [1:0]    cpu_sz, dma_sz;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
   logic          cpu_enable, dma_done, mem_req, mem_we, err, owner;
   logic [1:0]    mem_sz;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, rdata;

   typedef struct {
      logic          own;
      logic [DW-1:0] rd;
      logic          er;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sz(cpu_sz), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_enable(cpu_enable),
      .dma_req(dma_req), .dma_we(dma_we), .dma_sz(dma_sz), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_done(dma_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sz(mem_sz), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rdata(rdata), .err(err), .owner(owner)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic own, input logic [DW-1:0] rd, input logic er);
      exp_t e;
      e.own = own;
      e.rd  = rd;
      e.er  = er;
      sb.push_back(e);
   endtask

   // Walks the XFER phase: checks the bus every cycle, acks after 'delay' cycles
   task automatic do_xfer(input string tag, input int delay, input logic [DW-1:0] rd,
                          input logic we, input logic [1:0] sz, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic own, input logic cen);
      for (int i = 0; i <= delay; i++) begin
         @(negedge clk);
         chk({tag, "_mem_req"}, 64'(mem_req), 64'(1'b1));
         chk({tag, "_mem_we"}, 64'(mem_we), 64'(we));
         chk({tag, "_mem_sz"}, 64'(mem_sz), 64'(sz));
         chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
         chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wd));
         chk({tag, "_owner"}, 64'(owner), 64'(own));
         chk({tag, "_cpu_enable"}, 64'(cpu_enable), 64'(cen));
         chk({tag, "_no_pulse"}, 64'(dma_done), 64'(1'b0));
         if (i == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
         end
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
   endtask

   // Called on the expected DONE cycle: pops the scoreboard and checks the outcome
   task automatic check_done(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk({tag, "_owner"}, 64'(owner), 64'(e.own));
         chk({tag, "_pulse"}, 64'(e.own ? dma_done : cpu_enable), 64'(1'b1));
         chk({tag, "_other_pulse"}, 64'(e.own ? 1'b0 : dma_done), 64'(1'b0));
         chk({tag, "_rdata"}, 64'(rdata), 64'(e.rd));
         chk({tag, "_err"}, 64'(err), 64'(e.er));
         chk({tag, "_mem_req_low"}, 64'(mem_req), 64'(1'b0));
         $display("txn %s owner=%0d rdata=%0h err=%0d", tag, owner, rdata, err);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_sz = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_sz = 0; dma_addr = '0; dma_wdata = '0;
      mem_ack = 0; mem_rdata = '0;

      // reset state
      #1;
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_mem_sz", 64'(mem_sz), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_dma_done", 64'(dma_done), 64'(0));
      chk("rst_owner", 64'(owner), 64'(0));
      chk("rst_cpu_enable", 64'(cpu_enable), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_cpu_enable", 64'(cpu_enable), 64'(1));

      // CPU read, ack on first XFER cycle
      cpu_req = 1; cpu_we = 0; cpu_sz = 2; cpu_addr = 32'h100; cpu_wdata = '0;
      push(1'b0, 48'h0000DEADBEEF, 1'b0);
      do_xfer("cpu_rd", 0, 48'h0000DEADBEEF, 1'b0, 2'd2, 32'h100, '0, 1'b0, 1'b0);
      check_done("cpu_rd");
      cpu_req = 0;
      @(negedge clk);
      chk("cpu_rd_back_idle", 64'(cpu_enable), 64'(1));

      // tie after reset: CPU first, then DMA, then CPU again on the next tie
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_sz = 1; cpu_addr = 32'h200;
      dma_req = 1; dma_we = 0; dma_sz = 3; dma_addr = 32'h300; dma_wdata = 48'hABC;
      push(1'b0, 48'h111, 1'b0);
      do_xfer("tie1_cpu", 0, 48'h111, 1'b0, 2'd1, 32'h200, '0, 1'b0, 1'b0);
      check_done("tie1_cpu");
      cpu_req = 0;
      @(negedge clk);
      push(1'b1, 48'h222, 1'b0);
      do_xfer("tie1_dma", 0, 48'h222, 1'b0, 2'd3, 32'h300, 48'hABC, 1'b1, 1'b1);
      check_done("tie1_dma");
      dma_req = 0;
      @(negedge clk);
      cpu_req = 1; dma_req = 1;
      push(1'b0, 48'h333, 1'b0);
      do_xfer("tie2_cpu", 1, 48'h333, 1'b0, 2'd1, 32'h200, '0, 1'b0, 1'b0);
      check_done("tie2_cpu");
      cpu_req = 0;
      @(negedge clk);
      push(1'b1, 48'h444, 1'b0);
      do_xfer("tie2_dma", 0, 48'h444, 1'b0, 2'd3, 32'h300, 48'hABC, 1'b1, 1'b1);
      check_done("tie2_dma");
      dma_req = 0;
      @(negedge clk);

      // DMA write with a 5-cycle ack delay; rdata must keep the last read value
      dma_req = 1; dma_we = 1; dma_sz = 1; dma_addr = 32'h40; dma_wdata = 48'h1234;
      push(1'b1, 48'h444, 1'b0);
      do_xfer("dma_wr", 5, 48'hFFFF_FFFF_FFFF, 1'b1, 2'd1, 32'h40, 48'h1234, 1'b1, 1'b1);
      check_done("dma_wr");
      chk("dma_wr_cpu_enable", 64'(cpu_enable), 64'(1));
      dma_req = 0;
      @(negedge clk);

      // timeout: no ack for 15 XFER cycles
      cpu_req = 1; cpu_we = 0; cpu_sz = 0; cpu_addr = 32'h500;
      push(1'b0, 48'h0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("tmo_mem_req", 64'(mem_req), 64'(1));
         chk("tmo_cpu_stall", 64'(cpu_enable), 64'(0));
      end
      @(negedge clk);
      check_done("tmo");
      cpu_req = 0;
      @(negedge clk);
      chk("tmo_err_cleared", 64'(err), 64'(0));

      // reset in the middle of a DMA transfer
      dma_req = 1; dma_we = 0; dma_sz = 2; dma_addr = 32'h80; dma_wdata = '0;
      @(negedge clk);
      chk("rstx_mem_req", 64'(mem_req), 64'(1));
      chk("rstx_owner", 64'(owner), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rstx_async_mem_req", 64'(mem_req), 64'(0));
      chk("rstx_async_owner", 64'(owner), 64'(0));
      chk("rstx_cpu_enable", 64'(cpu_enable), 64'(0));
      @(negedge clk);
      chk("rstx_no_done", 64'(dma_done), 64'(0));
      rst_n = 1'b1;
      push(1'b1, 48'h555, 1'b0);
      do_xfer("rstx_new", 1, 48'h555, 1'b0, 2'd2, 32'h80, '0, 1'b1, 1'b1);
      check_done("rstx_new");
      dma_req = 0;
      @(negedge clk);

      // stray ack while idle
      mem_ack = 1; mem_rdata = 48'h999;
      @(negedge clk);
      mem_ack = 0; mem_rdata = '0;
      chk("stray_mem_req", 64'(mem_req), 64'(0));
      chk("stray_dma_done", 64'(dma_done), 64'(0));
      chk("stray_err", 64'(err), 64'(0));
      chk("stray_rdata", 64'(rdata), 64'(48'h555));
      @(negedge clk);
      chk("stray_rdata2", 64'(rdata), 64'(48'h555));
      chk("stray_dma_done2", 64'(dma_done), 64'(0));
      $display("txn stray_ack rdata=%0h", rdata);

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 48, data bus width (max instruction size).
REQ-003 SHALL have parameter TIMEOUT, default 15, max wait cycles for mem_ack before abort.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-005 SHALL have ports cpu_req in 1; cpu_we in 1; cpu_sz in 2 (0=8b, 1=16b, 2=32b, 3=48b); cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_enable out 1, drives Cpu enable.
REQ-006 SHALL have ports dma_req in 1; dma_we in 1; dma_sz in 2; dma_addr in ADDR_W; dma_wdata in DATA_W; dma_done out 1.
REQ-007 SHALL have ports mem_req out 1; mem_we out 1; mem_sz out 2; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_ack in 1; mem_rdata in DATA_W.
REQ-008 SHALL have ports rdata out DATA_W, shared read data to both masters; err out 1, timeout pulse; owner out 1 (0=CPU, 1=DMA).

Function
REQ-009 SHALL implement the FSM states IDLE, XFER and DONE.
REQ-010 SHALL sample cpu_req/dma_req in IDLE and latch the winner's we/sz/addr/wdata into the mem_* registers; mem_req SHALL rise the next cycle (XFER).
REQ-011 SHALL arbitrate round-robin: on simultaneous requests, grant the master not granted last; last-grant SHALL reset to DMA, so CPU wins the first tie.
REQ-012 SHALL hold mem_req and all mem_* outputs stable in XFER until a cycle with mem_ack=1; that cycle SHALL register mem_rdata into rdata (reads only) and go to DONE.
REQ-013 SHALL keep rdata unchanged on write transfers.
REQ-014 In DONE (1 cycle), SHALL deassert mem_req, pulse cpu_enable=1 (CPU owner) or dma_done=1 (DMA owner), then return to IDLE.
REQ-015 SHALL drive cpu_enable=0 whenever cpu_req=1 and the CPU transfer is not in DONE; cpu_enable=1 otherwise, including while DMA owns the port and cpu_req=0.
REQ-016 Minimum latency: request in IDLE at cycle N, mem_ack at N+1 -> completion pulse at N+2.
REQ-017 SHALL count XFER cycles with a counter; if the count reaches TIMEOUT without mem_ack, SHALL abort, drive rdata=0, pulse err=1 with the DONE completion pulse, and set the counter to 0.
REQ-018 SHALL ignore mem_ack outside XFER.
REQ-019 SHALL not abort an accepted transfer when its master deasserts req mid-XFER; the transfer SHALL complete and the completion pulse SHALL still fire.
REQ-020 SHALL require masters to hold req until their completion pulse; a req still high in the cycle after DONE SHALL count as a new request.
REQ-021 owner SHALL update only when IDLE grants a request and SHALL hold its value otherwise.

Reset
REQ-022 On rst_n=0, SHALL immediately (async) force: state IDLE; mem_req=0, mem_we=0, mem_sz=0, mem_addr=0, mem_wdata=0; rdata=0; err=0; dma_done=0; owner=0; last-grant=DMA; timeout counter=0.
REQ-023 During reset, cpu_enable SHALL be 0.
REQ-024 A reset during XFER SHALL drop mem_req with no completion pulse; after release, re-requests SHALL be treated as new.

Verification
REQ-025 CPU read: cpu_req=1, sz=2, addr=0x100; mem_ack at first XFER cycle with rdata=0x0000DEADBEEF -> mem_req for 1 cycle, rdata=0x0000DEADBEEF, cpu_enable pulses 1 two cycles after request.
REQ-026 Tie after reset: cpu_req and dma_req rise together -> CPU granted first (owner=0), then DMA (owner=1); repeated tie after -> CPU again.
REQ-027 DMA write, CPU idle: dma_we=1, addr=0x40, wdata=0x1234; mem_ack delayed 5 cycles -> mem_* stable for 6 cycles, dma_done pulse, rdata unchanged, cpu_enable stays 1.
REQ-028 Timeout: CPU read, mem_ack never asserted, TIMEOUT=15 -> abort after 15 XFER cycles, err=1 and cpu_enable=1 for one cycle, rdata=0.
REQ-029 Reset mid-XFER: rst_n low during DMA XFER -> mem_req=0 asynchronously, no dma_done; after release with dma_req still 1 -> new transfer starts.
REQ-030 Late/stray ack: mem_ack pulsed in IDLE -> no state change, no completion pulse.
